// File: rtl/cpu_boot_ctrl_if.sv
// cpu_boot_ctrl_if: lock/button/programmer inputs and reset/mode outputs of the boot sequencer
// master drives locked, prog_btn, upg_done and observes cpu_rst, upg_rst, prog_mode, state_dbg; slave is the sequencer side
interface cpu_boot_ctrl_if;
  logic       locked;
  logic       prog_btn;
  logic       upg_done;
  logic       cpu_rst;
  logic       upg_rst;
  logic       prog_mode;
  logic [2:0] state_dbg;
  modport master (output locked, prog_btn, upg_done, input cpu_rst, upg_rst, prog_mode, state_dbg);
  modport slave (input locked, prog_btn, upg_done, output cpu_rst, upg_rst, prog_mode, state_dbg);
endinterface

// File: rtl/cpu_boot_ctrl.sv
// cpu_boot_ctrl: PLL-lock reset sequencer with debounced run/programmer mode toggle
// ports: clock, reset_n (async active-low); bus.slave in: locked, prog_btn, upg_done; out: cpu_rst, upg_rst, prog_mode, state_dbg
module cpu_boot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 220000,
  parameter int RST_HOLD = 16,
  parameter int CNT_W = 18
) (
  input logic clock,
  input logic reset_n,
  cpu_boot_ctrl_if.slave bus
);
  typedef enum logic [2:0] {WAIT_LOCK = 3'd0, HOLD = 3'd1, RUN = 3'd2, PROG = 3'd3, EXIT = 3'd4} state_t;
  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(RST_HOLD - 1);
  state_t st, ns;
  logic [1:0] l_q, b_q, u_q;
  logic btn_st, btn_d, u_d;
  logic [CNT_W-1:0] dcnt, hcnt;
  logic locked_s, btn_s, done_s, press, done_p;
  assign locked_s = l_q[1];
  assign btn_s = b_q[1];
  assign done_s = u_q[1];
  assign press = btn_st & ~btn_d;
  assign done_p = done_s & ~u_d;
  assign bus.state_dbg = st;
  always_comb begin
    ns = st;
    case (st)
      WAIT_LOCK: ns = locked_s ? HOLD : WAIT_LOCK;
      HOLD, EXIT: ns = (hcnt == HMAX) ? RUN : st;
      RUN: ns = press ? PROG : RUN;
      PROG: ns = (press | done_p) ? EXIT : PROG;
      default: ns = WAIT_LOCK;
    endcase
    if (!locked_s) ns = WAIT_LOCK;
  end
  // outputs are decoded from the next state so they change together with state_dbg
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st <= WAIT_LOCK;
      l_q <= '0;
      b_q <= '0;
      u_q <= '0;
      btn_st <= 1'b0;
      btn_d <= 1'b0;
      u_d <= 1'b0;
      dcnt <= '0;
      hcnt <= '0;
      bus.cpu_rst <= 1'b1;
      bus.upg_rst <= 1'b1;
      bus.prog_mode <= 1'b0;
    end else begin
      st <= ns;
      l_q <= {l_q[0], bus.locked};
      b_q <= {b_q[0], bus.prog_btn};
      u_q <= {u_q[0], bus.upg_done};
      btn_st <= (btn_s != btn_st && dcnt == DMAX) ? btn_s : btn_st;
      btn_d <= btn_st;
      u_d <= done_s;
      dcnt <= (btn_s == btn_st || dcnt == DMAX) ? '0 : dcnt + 1'b1;
      // restarts at 0 on every state change, so HOLD and EXIT each see a fresh count
      hcnt <= (ns != st) ? '0 : hcnt + 1'b1;
      bus.cpu_rst <= ns != RUN;
      bus.upg_rst <= ns != PROG;
      bus.prog_mode <= ns == PROG;
    end
  end
endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb_cpu_boot_ctrl: directed check of lock-up, debounce, programming entry/exit, lock loss and async reset
module tb_cpu_boot_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  cpu_boot_ctrl_if bus ();
  cpu_boot_ctrl #(.DEBOUNCE_CYCLES(8), .RST_HOLD(4), .CNT_W(4)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [2:0] st, input logic cr, input logic ur, input logic pm);
    chk({tag, ".state"}, bus.state_dbg, st);
    chk({tag, ".cpu_rst"}, {2'b0, bus.cpu_rst}, {2'b0, cr});
    chk({tag, ".upg_rst"}, {2'b0, bus.upg_rst}, {2'b0, ur});
    chk({tag, ".prog_mode"}, {2'b0, bus.prog_mode}, {2'b0, pm});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    bus.locked = 1'b0;
    bus.prog_btn = 1'b0;
    bus.upg_done = 1'b0;
    cyc(3);
    chk_out("reset", 3'd0, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc(1);
      chk("nolock.state", bus.state_dbg, 3'd0);
      chk("nolock.cpu_rst", {2'b0, bus.cpu_rst}, 3'd1);
    end
    bus.locked = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      chk("lockup.state", bus.state_dbg, k < 3 ? 3'd0 : (k < 7 ? 3'd1 : 3'd2));
      chk("lockup.cpu_rst", {2'b0, bus.cpu_rst}, {2'b0, k < 7});
    end
    chk_out("run", 3'd2, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      bus.prog_btn = ~bus.prog_btn;
      for (int j = 0; j < 3; j++) begin
        cyc(1);
        chk("bounce.state", bus.state_dbg, 3'd2);
      end
    end
    bus.prog_btn = 1'b1;
    cyc(10);
    chk_out("press_m1", 3'd2, 1'b0, 1'b1, 1'b0);
    cyc(1);
    chk_out("press", 3'd3, 1'b1, 1'b0, 1'b1);
    bus.prog_btn = 1'b0;
    bus.upg_done = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cyc(1);
      chk("exit.state", bus.state_dbg, k < 3 ? 3'd3 : (k < 7 ? 3'd4 : 3'd2));
      chk("exit.cpu_rst", {2'b0, bus.cpu_rst}, {2'b0, k < 7});
      chk("exit.upg_rst", {2'b0, bus.upg_rst}, {2'b0, k >= 3});
      if (k == 5) bus.upg_done = 1'b0;
    end
    cyc(8);
    chk_out("settle", 3'd2, 1'b0, 1'b1, 1'b0);
    bus.upg_done = 1'b1;
    cyc(4);
    chk("done_in_run", bus.state_dbg, 3'd2);
    bus.prog_btn = 1'b1;
    cyc(11);
    chk("stale.enter", bus.state_dbg, 3'd3);
    bus.prog_btn = 1'b0;
    for (int k = 0; k < 15; k++) begin
      cyc(1);
      chk("stale.hold", bus.state_dbg, 3'd3);
    end
    bus.upg_done = 1'b0;
    cyc(4);
    chk("stale.low", bus.state_dbg, 3'd3);
    bus.upg_done = 1'b1;
    cyc(2);
    chk("fresh.m1", bus.state_dbg, 3'd3);
    cyc(1);
    chk("fresh.exit", bus.state_dbg, 3'd4);
    cyc(4);
    chk_out("fresh.run", 3'd2, 1'b0, 1'b1, 1'b0);
    bus.upg_done = 1'b0;
    bus.prog_btn = 1'b1;
    cyc(11);
    chk("press2.enter", bus.state_dbg, 3'd3);
    bus.prog_btn = 1'b0;
    cyc(14);
    chk("press2.release", bus.state_dbg, 3'd3);
    bus.prog_btn = 1'b1;
    cyc(10);
    chk("press2.m1", bus.state_dbg, 3'd3);
    cyc(1);
    chk("press2.exit", bus.state_dbg, 3'd4);
    bus.prog_btn = 1'b0;
    cyc(4);
    chk_out("press2.run", 3'd2, 1'b0, 1'b1, 1'b0);
    cyc(14);
    bus.prog_btn = 1'b1;
    cyc(11);
    chk("loss.enter", bus.state_dbg, 3'd3);
    bus.prog_btn = 1'b0;
    cyc(2);
    bus.locked = 1'b0;
    bus.upg_done = 1'b1;
    cyc(2);
    chk("loss.m1", bus.state_dbg, 3'd3);
    cyc(1);
    chk_out("loss", 3'd0, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("loss.stay", bus.state_dbg, 3'd0);
    end
    bus.upg_done = 1'b0;
    bus.locked = 1'b1;
    cyc(3);
    chk("arst.hold", bus.state_dbg, 3'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk_out("arst", 3'd0, 1'b1, 1'b1, 1'b0);
    reset_n = 1'b1;
    cyc(6);
    chk_out("relock.hold", 3'd1, 1'b1, 1'b1, 1'b0);
    cyc(1);
    chk_out("relock.run", 3'd2, 1'b0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_boot_ctrl.md
Name: cpu_boot_ctrl

Overview:
- Reset and run-mode sequencer in the cpu_clk domain, directly downstream of the cpuclk clocking block.
- Waits for the PLL lock and holds the CPU in reset for a fixed count after lock.
- A debounced push-button toggles between CPU run and UART-programmer (upg) mode.
- Drives the synchronous CPU reset, the programmer reset and a mode flag to the top level.

Parameters:
- DEBOUNCE_CYCLES, 220000: cycles the synchronised button must hold a new level before it is accepted (10 ms at 22 MHz).
- RST_HOLD, 16: cycles cpu_rst stays high after lock, or after leaving programming mode. Must be >= 1.
- CNT_W, 18: width of the shared counter. Must hold max(DEBOUNCE_CYCLES, RST_HOLD) - 1.

Ports:
- clock  in  1  cpu_clk (clk_out1 of cpuclk, 22 MHz).
- reset_n  in  1  asynchronous active-low reset; clears all state.
- locked  in  1  PLL lock from cpuclk, asynchronous to clock.
- prog_btn  in  1  raw push-button, active high, asynchronous, bouncy.
- upg_done  in  1  level from the programmer (upg_clk domain); high when a download is complete.
- cpu_rst  out  1  synchronous active-high CPU reset.
- upg_rst  out  1  active-high programmer reset.
- prog_mode  out  1  high while in programming mode.
- state_dbg  out  3  current FSM state encoding.

Behaviour:
- Reset (reset_n=0): cpu_rst=1, upg_rst=1, prog_mode=0, state=WAIT_LOCK(0). Counters and synchroniser flops are cleared to 0.
- Synchronisers: locked, prog_btn and upg_done each pass through 2 flops. Only the synchronised versions are used.
- Debounce:
  - Counter dcnt compares btn_s with the accepted level btn_st.
  - If they are equal, dcnt=0.
  - Otherwise dcnt increments. When dcnt==DEBOUNCE_CYCLES-1, btn_st takes btn_s and dcnt clears.
  - press is a 1-cycle pulse on a 0->1 transition of btn_st. A release generates nothing.
- upg_done edge: done_p is a 1-cycle pulse on a 0->1 transition of the synchronised upg_done.
- FSM (registered outputs, values take effect the cycle after the transition):
  - WAIT_LOCK(0):
    - Outputs: cpu_rst=1, upg_rst=1, prog_mode=0.
    - When locked_s=1: load hcnt=0 and go to HOLD.
  - HOLD(1):
    - Outputs: cpu_rst=1, upg_rst=1.
    - hcnt increments each cycle. At hcnt==RST_HOLD-1, go to RUN.
    - Exactly RST_HOLD cycles are spent in HOLD.
  - RUN(2):
    - Outputs: cpu_rst=0, upg_rst=1, prog_mode=0.
    - On press, go to PROG.
  - PROG(3):
    - Outputs: cpu_rst=1, upg_rst=0, prog_mode=1.
    - On done_p or press (either or both in the same cycle, giving a single exit), load hcnt=0 and go to EXIT.
  - EXIT(4):
    - Outputs: cpu_rst=1, upg_rst=1, prog_mode=0.
    - Counts RST_HOLD cycles as in HOLD, then goes to RUN.
  - Encodings 5-7 are illegal and go to WAIT_LOCK on the next cycle.
- Priority: locked_s=0 in any state except WAIT_LOCK forces WAIT_LOCK on the next edge. This overrides press and done_p in the same cycle.
- Press handling outside RUN/PROG: a press during WAIT_LOCK, HOLD or EXIT is discarded, not queued.
- Latency:
  - locked rising edge to cpu_rst falling edge = 2 (sync) + 1 (WAIT_LOCK→HOLD) + RST_HOLD cycles.
  - Accepted press to prog_mode=1 = 1 cycle after the press pulse.
- upg_done held high on entry to PROG does not cause an exit; only a fresh rising edge does.
- reset_n asserted mid-operation returns immediately to the reset values above, including debounce state.

Test Plan (DEBOUNCE_CYCLES=8, RST_HOLD=4, CNT_W=4):
- Lock-up: release reset_n with locked=0 for 20 cycles, then locked=1 → cpu_rst=1 throughout; cpu_rst falls exactly 7 cycles after locked rises; state_dbg goes 0→1→2.
- Debounce: in RUN, toggle prog_btn every 3 cycles for 30 cycles, then hold it at 1 → no mode change while toggling; prog_mode=1, upg_rst=0 and cpu_rst=1 exactly 8+2+1 cycles after the final rise.
- Programming exit: in PROG, pulse upg_done high for 5 cycles → state goes 3→4; cpu_rst stays 1 for 4 more cycles; then RUN with cpu_rst=0 and upg_rst=1.
- Lock loss: drop locked during PROG in the same cycle that done_p fires → state=0, cpu_rst=1, upg_rst=1, prog_mode=0; EXIT is never entered.
- Stale done: hold upg_done=1 before entering PROG → the FSM stays in PROG until upg_done falls and rises again, or until a second press.
- Async reset: assert reset_n for 1 ns mid-HOLD, between clock edges → outputs return to reset values immediately without waiting for a clock edge, and state_dbg=0.
